// File: rtl/cordic_output_buffer.sv
// cordic_output_buffer: FIFO capturing CORDIC pipeline results with in-flight credit tracking.
// Define CORDIC_OUT_OVF_EN to add the sticky overflow output.
module cordic_output_buffer #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic        valid_in,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic        ready_in,
  output logic        valid_out,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
`ifdef CORDIC_OUT_OVF_EN
  output logic        overflow,
`endif
  output logic        credit_ok
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [47:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] occ, infl, infl_nxt;
  logic push, pop;
  assign valid_out = occ != '0;
  assign pop = valid_out && ready_in;
  assign push = valid_in && (occ < FULL || pop);
  assign {x_out, y_out, z_out} = mem[rd_ptr];
  assign credit_ok = ({1'b0, occ} + {1'b0, infl}) < {1'b0, FULL};
  // issue saturates at DEPTH; arrivals with nothing tracked leave infl at 0
  always_comb begin
    infl_nxt = infl;
    if (issue && !valid_in) infl_nxt = (infl == FULL) ? infl : infl + CNT_W'(1);
    else if (!issue && valid_in) infl_nxt = (infl == '0) ? infl : infl - CNT_W'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      infl <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {x_in, y_in, z_in};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
      infl <= infl_nxt;
    end
  end
`ifdef CORDIC_OUT_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (valid_in && !push) overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_cordic_output_buffer.sv
// tb_cordic_output_buffer: randomized and directed checks against a queue-based reference model.
module tb_cordic_output_buffer;
  localparam int DEPTH = 8;
  logic clk = 0, reset = 1, issue = 0, valid_in = 0, ready_in = 0;
  logic [15:0] x_in = 0, y_in = 0, z_in = 0;
  logic valid_out, credit_ok;
  logic [15:0] x_out, y_out, z_out;
`ifdef CORDIC_OUT_OVF_EN
  logic overflow;
`endif
  int checks = 0, errors = 0;
  logic [47:0] q[$];
  int infl = 0;
  bit ovf = 0;

  cordic_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .issue(issue), .valid_in(valid_in),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .ready_in(ready_in),
    .valid_out(valid_out), .x_out(x_out), .y_out(y_out), .z_out(z_out),
`ifdef CORDIC_OUT_OVF_EN
    .overflow(overflow),
`endif
    .credit_ok(credit_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":valid"}, 48'(valid_out), 48'(q.size() != 0));
    if (q.size() != 0) chk({tag, ":data"}, {x_out, y_out, z_out}, q[0]);
    chk({tag, ":credit"}, 48'(credit_ok), 48'(q.size() + infl < DEPTH));
`ifdef CORDIC_OUT_OVF_EN
    chk({tag, ":ovf"}, 48'(overflow), 48'(ovf));
`endif
  endtask

  task automatic step(input string tag, input logic iss, input logic vi,
                      input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                      input logic rdy);
    bit p, w;
    issue = iss; valid_in = vi; x_in = x; y_in = y; z_in = z; ready_in = rdy;
    p = q.size() != 0 && rdy;
    w = vi && (q.size() < DEPTH || p);
    if (p) void'(q.pop_front());
    if (w) q.push_back({x, y, z});
    if (vi && !w) ovf = 1;
    infl = infl + int'(iss) - int'(vi);
    if (infl < 0) infl = 0;
    if (infl > DEPTH) infl = DEPTH;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1; issue = 0; valid_in = 0; ready_in = 0;
    #1;
    chk("rst:valid", 48'(valid_out), 48'd0);
    chk("rst:credit", 48'(credit_ok), 48'd1);
    chk("rst:data", {x_out, y_out, z_out}, 48'd0);
`ifdef CORDIC_OUT_OVF_EN
    chk("rst:ovf", 48'(overflow), 48'd0);
`endif
    q.delete(); infl = 0; ovf = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #12;
    do_reset();
    for (int i = 1; i <= 5; i++) step("fill5", 0, 1, 16'(i), 16'(i), 16'(i), 0);
    #3;
    do_reset();
    step("post_rst", 0, 1, 16'h1234, 16'h0ABC, 16'hFFF0, 0);
    chk("post_rst:x", 48'(x_out), 48'h1234);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("issue", 1, 0, 0, 0, 0, 0);
    chk("credit_low", 48'(credit_ok), 48'd0);
    step("arrive", 0, 1, 16'h55, 16'h66, 16'h77, 0);
    chk("credit_still_low", 48'(credit_ok), 48'd0);
    step("pop", 0, 0, 0, 0, 0, 1);
    chk("credit_back", 48'(credit_ok), 48'd1);
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step("bp_fill", 0, 1, 16'(i), 16'(i + 100), 16'(i + 200), 0);
    chk("bp_hold", 48'(x_out), 48'd1);
    step("full_pushpop", 0, 1, 16'd9, 16'd109, 16'd209, 1);
    chk("full_pushpop:x", 48'(x_out), 48'd2);
    for (int i = 0; i < DEPTH; i++) step("drain1", 0, 0, 0, 0, 0, 1);
    chk("drained", 48'(valid_out), 48'd0);
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step("ovf_fill", 0, 1, 16'(i), 0, 0, 0);
    step("drop", 0, 1, 16'd9, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 48'(x_out), 48'(i + 1));
      step("drain2", 0, 0, 0, 0, 0, 1);
    end
    do_reset();
    for (int i = 0; i < 20; i++) step("wrap", 0, 1, 16'(i), 16'(~i), 16'(i * 3), 1);
    step("wrap_tail", 0, 0, 0, 0, 0, 1);
    chk("wrap_empty", 48'(valid_out), 48'd0);
    do_reset();
    for (int i = 0; i < 3000; i++)
      step("rand", credit_ok ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
